// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and buart-side signals around the UART TX arbiter.
// The slave modport is the arbiter. The master modport is its environment:
// the two byte producers and the buart transmitter.
interface uart_tx_arbiter_if;
  logic       a_wr;
  logic [7:0] a_data;
  logic       a_lock;
  logic       a_full;
  logic       b_wr;
  logic [7:0] b_data;
  logic       b_lock;
  logic       b_full;
  logic [1:0] ovf;
  logic       owner;
  logic       locked;
  logic       uart_wr;
  logic [7:0] uart_tx_data;
  logic       uart_busy;

  modport master (
    output a_wr, a_data, a_lock, b_wr, b_data, b_lock, uart_busy,
    input  a_full, b_full, ovf, owner, locked, uart_wr, uart_tx_data
  );

  modport slave (
    input  a_wr, a_data, a_lock, b_wr, b_data, b_lock, uart_busy,
    output a_full, b_full, ovf, owner, locked, uart_wr, uart_tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one buart transmitter between requester A and
// requester B. Each requester has a one-byte holding register. An optional
// per-requester lock keeps multi-byte packets together. The FSM hides the
// one-cycle lag between the buart wr strobe and its busy flag.
module uart_tx_arbiter #(
  parameter int LOCK_TIMEOUT = 4096,
  parameter int CNT_W        = 13
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [7:0]         hold_a_q, hold_a_d;
  logic [7:0]         hold_b_q, hold_b_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               a_full_q, a_full_d;
  logic               b_full_q, b_full_d;
  logic [1:0]         ovf_q, ovf_d;
  logic               owner_q, owner_d;
  logic               locked_q, locked_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               owner_lock;
  logic               owner_full;
  logic               lock_eff;
  logic               go;
  logic               sel;

  assign owner_lock = owner_q ? bus.b_lock : bus.a_lock;
  assign owner_full = owner_q ? b_full_q : a_full_q;
  assign cnt_inc    = cnt_q + 1'b1;

  // Holding registers: capture when empty, flag overrun when occupied,
  // release the granted requester's register at the end of ISSUE.
  always_comb begin
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    a_full_d = a_full_q;
    b_full_d = b_full_q;
    ovf_d    = ovf_q;
    if (state_q == ISSUE && !owner_q) a_full_d = 1'b0;
    if (state_q == ISSUE &&  owner_q) b_full_d = 1'b0;
    if (bus.a_wr) begin
      if (a_full_q) begin
        ovf_d[0] = 1'b1;
      end else begin
        hold_a_d = bus.a_data;
        a_full_d = 1'b1;
      end
    end
    if (bus.b_wr) begin
      if (b_full_q) begin
        ovf_d[1] = 1'b1;
      end else begin
        hold_b_d = bus.b_data;
        b_full_d = 1'b1;
      end
    end
  end

  // Arbitration FSM with lock release and lock timeout counter.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    locked_d  = locked_q;
    tx_data_d = tx_data_q;
    cnt_d     = '0;
    lock_eff  = locked_q;
    go        = 1'b0;
    sel       = owner_q;
    case (state_q)
      IDLE: begin
        if (locked_q) begin
          if (!owner_lock) begin
            // Owner let go: normal arbitration applies this same cycle.
            locked_d = 1'b0;
            lock_eff = 1'b0;
          end else if (!owner_full) begin
            cnt_d = cnt_inc;
            if (LOCK_TIMEOUT != 0 && cnt_inc == CNT_W'(LOCK_TIMEOUT)) begin
              locked_d = 1'b0;
              cnt_d    = '0;
            end
          end
        end
        if (lock_eff) begin
          go  = owner_full;
          sel = owner_q;
        end else if (a_full_q && b_full_q) begin
          go  = 1'b1;
          sel = ~owner_q;
        end else if (a_full_q) begin
          go  = 1'b1;
          sel = 1'b0;
        end else if (b_full_q) begin
          go  = 1'b1;
          sel = 1'b1;
        end
        if (go && !bus.uart_busy) begin
          state_d   = ISSUE;
          owner_d   = sel;
          tx_data_d = sel ? hold_b_q : hold_a_q;
        end
      end
      ISSUE: begin
        locked_d = owner_lock;
        state_d  = SETTLE;
      end
      // buart raises busy one cycle after wr, so busy is not trusted here.
      SETTLE: state_d = DRAIN;
      DRAIN: begin
        if (!bus.uart_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_full_q  <= 1'b0;
      b_full_q  <= 1'b0;
      ovf_q     <= 2'b00;
      owner_q   <= 1'b1;
      locked_q  <= 1'b0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      a_full_q  <= a_full_d;
      b_full_q  <= b_full_d;
      ovf_q     <= ovf_d;
      owner_q   <= owner_d;
      locked_q  <= locked_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Holding data registers; contents are only meaningful while full is set.
  always_ff @(posedge clk) begin
    hold_a_q <= hold_a_d;
    hold_b_q <= hold_b_d;
  end

  assign bus.a_full       = a_full_q;
  assign bus.b_full       = b_full_q;
  assign bus.ovf          = ovf_q;
  assign bus.owner        = owner_q;
  assign bus.locked       = locked_q;
  assign bus.uart_tx_data = tx_data_q;
  assign bus.uart_wr      = (state_q == ISSUE) && !reset;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single buart transmit channel between two byte producers: requester A (CPU I/O write path) and requester B (hardware trace/monitor source).
- Each requester gets a one-byte holding register. Arbitration is round-robin, with an optional per-requester lock so multi-byte packets are not interleaved.
- The block sequences the buart write strobe and hides its one-cycle busy lag.
- Sits between the requesters and buart's wr/tx_data/busy pins. The buart receive side is untouched.

Parameters:
- LOCK_TIMEOUT, default 4096: cycles spent in IDLE with the lock owner's holding register empty before the lock is force-released. 0 disables the timeout.
- CNT_W, default 13: width of the lock timeout counter. Must hold LOCK_TIMEOUT.

Ports:
- clk  in  1  system clock (single clock domain)
- reset  in  1  synchronous, active-high reset
- a_wr  in  1  requester A write strobe, one cycle per byte
- a_data  in  8  requester A byte
- a_lock  in  1  requester A requests to keep the grant across bytes
- a_full  out  1  A holding register occupied; a_wr is ignored while high
- b_wr, b_data, b_lock, b_full: same as the A ports, for requester B
- ovf  out  2  sticky overrun flags, bit0=A, bit1=B
- owner  out  1  last/current granted requester (0=A, 1=B)
- locked  out  1  lock currently held by owner
- uart_wr  out  1  buart wr strobe
- uart_tx_data  out  8  buart tx_data
- uart_busy  in  1  buart busy

Behaviour:
- Reset values: uart_wr=0, uart_tx_data=0, a_full=b_full=0, ovf=0, owner=1, locked=0, state=IDLE, timeout counter=0.
  - Because owner resets to 1, A wins the first tie.
- Holding registers:
  - x_wr with x_full=0 captures x_data; x_full=1 from the next cycle.
  - x_wr with x_full=1: byte dropped, ovf[x] set. ovf[x] clears only on reset.
- FSM states: IDLE, ISSUE, SETTLE, DRAIN.
- IDLE:
  - Leaves only when uart_busy=0 and at least one requester is eligible.
  - Eligibility while locked=1: only the owner, and only if its full=1.
  - Eligibility while locked=0: if both are full, pick the requester that is not owner; otherwise pick the one that is full.
  - Latch the selection into owner and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - uart_wr=1 and uart_tx_data=hold[owner].
  - Clears full[owner] at the end of the cycle, so a write arriving in this cycle still sees full=1 and is an overrun.
  - locked <= lock input of owner.
  - Go to SETTLE.
- SETTLE (1 cycle): uart_busy is ignored here, because buart asserts busy one cycle after wr. Go to DRAIN.
- DRAIN: stay until uart_busy=0, then go to IDLE.
- uart_wr is 0 in every state except ISSUE. uart_tx_data holds its last value outside ISSUE.
- Lock release, checked in IDLE:
  - If the owner's lock input is 0, locked clears that cycle and normal arbitration applies the same cycle.
  - Otherwise, while the owner's full=0, the counter increments. When it reaches LOCK_TIMEOUT (nonzero), locked clears and the counter zeroes.
  - The counter zeroes whenever the owner becomes full or the FSM is not in IDLE.
- Latency with buart idle: x_wr at cycle t, full at t+1, IDLE decides at t+1, uart_wr high at t+2.
- Back-to-back throughput: one byte per buart frame plus 3 cycles.
- Power-up: buart holds busy after its own reset (dummy frame). The arbiter just waits in IDLE; no special case.
- Reset mid-operation: everything returns to reset values and held bytes are discarded. uart_wr is never asserted during the reset cycle.
- Simultaneous x_wr from both requesters in the same cycle: both captured independently.

Test Plan:
- Reset, then a_wr with 0x41 while uart_busy=0. Required: uart_wr is a single pulse 2 cycles later with tx_data=0x41, a_full drops the cycle after, owner=0.
- a_wr 0x11 and b_wr 0x22 in the same cycle, with busy modelled as 1 cycle after wr for 20 cycles. Required: 0x11 is sent first, then 0x22, each wr at least 3+20 cycles apart. Repeating the test gives the same order (owner alternates correctly).
- a_wr 0x55 while a_full=1. Required: ovf[0]=1, the first byte is still sent, 0x55 never appears, and ovf stays set until reset.
- a_lock=1, A sends 3 bytes while B is kept full. Required: all 3 A bytes go out before B's byte. After a_lock drops, B is sent next.
- LOCK_TIMEOUT=16, A locks, sends 1 byte and goes silent. Required: locked clears after 16 IDLE cycles and the pending B byte is then issued.
- Assert reset during DRAIN with b_full=1. Required: all outputs return to reset values the next cycle and no uart_wr pulse is issued for the discarded byte.
